// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state encoding, BCD limits and defaults for count_ctrl_fsm
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int          DIGITS_W     = 16;
    localparam logic [15:0] BCD_MIN      = 16'h0000;
    localparam logic [15:0] BCD_MAX      = 16'h9999;
    localparam int          DEF_TICK_DIV = 100_000_000;
    localparam int          DEF_DB_LEN   = 1_000_000;

    // Counting stops at the end of the range in the current direction; the chain never wraps.
    function automatic logic is_term(input logic dir, input logic [DIGITS_W-1:0] digits);
        return dir ? (digits == BCD_MIN) : (digits == BCD_MAX);
    endfunction

endpackage

// File: rtl/count_ctrl_fsm_if.sv
// rtl/count_ctrl_fsm_if.sv - control/value link between the run-control FSM and the BCD digit chain
interface count_ctrl_fsm_if;
    import count_ctrl_pkg::*;

    logic [DIGITS_W-1:0] digits;
    logic                increase;
    logic                decrease;
    logic                load_def;
    logic                switch_count;
    logic                switch_up_down;

    modport master (
        input  digits,
        output increase, decrease, load_def, switch_count, switch_up_down
    );

    modport slave (
        output digits,
        input  increase, decrease, load_def, switch_count, switch_up_down
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce filter and press event
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DB_LEN = DEF_DB_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_ev
);

    localparam int            CW      = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);

    logic          sync_1;
    logic          sync_2;
    logic          lvl;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            lvl    <= 1'b0;
            lvl_d  <= 1'b0;
            cnt    <= '0;
            btn_ev <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            lvl_d  <= lvl;
            btn_ev <= lvl & ~lvl_d;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_ctrl_fsm.sv
// rtl/count_ctrl_fsm.sv - run-control FSM, prescaler and direction latch driving the BCD counter chain
module count_ctrl_fsm
    import count_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DB_LEN   = DEF_DB_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_start,
    input  logic                     btn_load,
    input  logic                     mode_down,
    count_ctrl_fsm_if.master         chain,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic          start_ev;
    logic          load_ev;
    state_t        state_q;
    state_t        state_nx;
    logic [PW-1:0] pre_q;
    logic          dir_q;
    logic          tick;
    logic          term;
    logic          inc_nx;
    logic          dec_nx;
    logic          ld_nx;

    btn_debounce #(.DB_LEN(DB_LEN)) u_db_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_start),
        .btn_ev  (start_ev)
    );

    btn_debounce #(.DB_LEN(DB_LEN)) u_db_load (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_load),
        .btn_ev  (load_ev)
    );

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);
    assign term = is_term(dir_q, chain.digits);

    always_comb begin
        state_nx = state_q;
        inc_nx   = 1'b0;
        dec_nx   = 1'b0;
        ld_nx    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_ev) begin
                    ld_nx = 1'b1;
                end else if (start_ev) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_ev) begin
                    ld_nx    = 1'b1;
                    state_nx = ST_IDLE;
                end else if (start_ev) begin
                    state_nx = ST_PAUSE;
                end else if (tick) begin
                    if (term) begin
                        state_nx = ST_DONE;
                    end else begin
                        inc_nx = ~dir_q;
                        dec_nx = dir_q;
                    end
                end
            end
            ST_PAUSE: begin
                if (load_ev) begin
                    ld_nx    = 1'b1;
                    state_nx = ST_IDLE;
                end else if (start_ev) begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_ev || start_ev) begin
                    ld_nx    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            done           <= 1'b0;
            chain.increase <= 1'b0;
            chain.decrease <= 1'b0;
            chain.load_def <= 1'b0;
        end else begin
            state_q        <= state_nx;
            done           <= (state_nx == ST_DONE);
            chain.increase <= inc_nx;
            chain.decrease <= dec_nx;
            chain.load_def <= ld_nx;
        end
    end

    // Direction is frozen while counting so a mid-run switch cannot reverse the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (state_q != ST_RUN) begin
            dir_q <= mode_down;
        end
    end

    // Leaving RUN for PAUSE keeps the phase so a resume finishes the interrupted tick period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (state_q == ST_RUN && state_nx == ST_RUN) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end else if (state_nx == ST_IDLE || state_nx == ST_DONE) begin
            pre_q <= '0;
        end
    end

    assign chain.switch_up_down = dir_q;
    assign chain.switch_count   = ~dir_q;
    assign state                = state_q;

endmodule

// File: tb/tb_count_ctrl_fsm.sv
// tb/tb_count_ctrl_fsm.sv - self-checking bench for count_ctrl_fsm with a closed-loop BCD chain model
module tb_count_ctrl_fsm;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_load  = 1'b0;
    logic       mode_down = 1'b0;
    logic [1:0] state;
    logic       done;

    count_ctrl_fsm_if chain();

    count_ctrl_fsm #(.TICK_DIV(TD), .DB_LEN(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_load  (btn_load),
        .mode_down (mode_down),
        .chain     (chain),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int val     = 0;
    int dflt    = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign chain.digits = to_bcd(val);

    function automatic logic [7:0] obs();
        return {state, done, chain.increase, chain.decrease, chain.load_def,
                chain.switch_count, chain.switch_up_down};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: states 0 idle, 1 run, 2 pause, 3 done; debounce as a sliding window.
    logic [1:0] m_state;
    bit m_done, m_inc, m_dec, m_ld, m_dir;
    int m_run;
    bit m_ev_s, m_ev_l, m_lvl_s, m_lvl_l, m_old_s, m_old_l;
    bit h_s[$];
    bit h_l[$];

    function automatic bit window_differs(input bit q[$], input bit lvl);
        for (int j = 2; j < DB + 2; j++) begin
            if (q[j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic bs, input logic bl, input logic md,
                              input logic [15:0] dg);
        bit tick, term, ne_s, ne_l;
        logic [1:0] nst;
        if (!r) begin
            m_state = 2'd0; m_done = 0; m_inc = 0; m_dec = 0; m_ld = 0; m_dir = 0; m_run = 0;
            m_ev_s = 0; m_ev_l = 0; m_lvl_s = 0; m_lvl_l = 0; m_old_s = 0; m_old_l = 0;
            h_s.delete(); h_l.delete();
            for (int j = 0; j < DB + 2; j++) begin
                h_s.push_front(1'b0);
                h_l.push_front(1'b0);
            end
            return;
        end
        tick = (m_state == 2'd1) && (m_run % TD == TD - 1);
        term = m_dir ? (dg == 16'h0000) : (dg == 16'h9999);
        nst = m_state; m_inc = 0; m_dec = 0; m_ld = 0;
        case (m_state)
            2'd0: if (m_ev_l) m_ld = 1; else if (m_ev_s) nst = 2'd1;
            2'd1: if (m_ev_l) begin m_ld = 1; nst = 2'd0; end
                  else if (m_ev_s) nst = 2'd2;
                  else if (tick) begin
                      if (term) nst = 2'd3;
                      else if (m_dir) m_dec = 1;
                      else m_inc = 1;
                  end
            2'd2: if (m_ev_l) begin m_ld = 1; nst = 2'd0; end else if (m_ev_s) nst = 2'd1;
            default: if (m_ev_l || m_ev_s) begin m_ld = 1; nst = 2'd0; end
        endcase
        if (m_state == 2'd1 && nst == 2'd1) m_run++;
        else if (nst == 2'd0 || nst == 2'd3) m_run = 0;
        if (m_state != 2'd1) m_dir = md;
        ne_s = m_lvl_s & ~m_old_s; m_old_s = m_lvl_s;
        ne_l = m_lvl_l & ~m_old_l; m_old_l = m_lvl_l;
        h_s.push_front(bs); void'(h_s.pop_back());
        h_l.push_front(bl); void'(h_l.pop_back());
        if (window_differs(h_s, m_lvl_s)) m_lvl_s = ~m_lvl_s;
        if (window_differs(h_l, m_lvl_l)) m_lvl_l = ~m_lvl_l;
        m_ev_s = ne_s; m_ev_l = ne_l;
        m_state = nst;
        m_done = (nst == 2'd3);
    endtask

    task automatic step();
        int nval;
        if (!rst_n) nval = 0;
        else if (chain.load_def === 1'b1) nval = dflt;
        else if (chain.increase === 1'b1) nval = (val + 1) % 10000;
        else if (chain.decrease === 1'b1) nval = (val + 9999) % 10000;
        else nval = val;
        model_edge(rst_n, btn_start, btn_load, mode_down, chain.digits);
        @(posedge clk);
        #1;
        val = nval;
        chk("model", obs(), {m_state, m_done, m_inc, m_dec, m_ld, ~m_dir, m_dir});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct {
        bit bs; bit bl; bit md; int n;
        logic [1:0] st; bit dn; bit sc; bit ld;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int pulses;
        int cs;
        int cl;
        tbl[0] = '{0, 0, 0, 3, 2'b00, 0, 1, 0};
        tbl[1] = '{0, 0, 1, 2, 2'b00, 0, 0, 0};
        tbl[2] = '{1, 0, 1, 6, 2'b00, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 1, 2'b01, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 3, 2'b01, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 8, 2'b01, 0, 0, 0};
        tbl[6] = '{1, 0, 0, 7, 2'b10, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 8, 2'b10, 0, 1, 0};
        tbl[8] = '{0, 1, 0, 7, 2'b00, 0, 1, 1};
        tbl[9] = '{0, 0, 0, 8, 2'b00, 0, 1, 0};

        // Reset with buttons toggling
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            btn_start = ~btn_start; btn_load = ~btn_load;
            step();
        end
        chk("reset", obs(), 8'b00_0_0_0_0_1_0);
        rst_n = 1'b1; btn_start = 0; btn_load = 0; mode_down = 0;
        steps(8);

        // Table-driven run/pause/load flow
        val = 5; dflt = 0;
        for (int i = 0; i < 10; i++) begin
            btn_start = tbl[i].bs; btn_load = tbl[i].bl; mode_down = tbl[i].md;
            steps(tbl[i].n);
            chk($sformatf("vec%0d", i), obs(),
                {tbl[i].st, tbl[i].dn, 1'b0, 1'b0, tbl[i].ld, tbl[i].sc, ~tbl[i].sc});
        end

        // Up count, direction frozen in RUN, load priority over a coinciding tick
        val = 0; mode_down = 0; btn_start = 1;
        steps(6);
        chk("up_pre", state, 2'b00);
        step();
        chk("up_run", state, 2'b01);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) mode_down = 1;
            step();
            chk("up_pulse", {chain.increase, chain.switch_count}, {(i % 4 == 0), 1'b1});
            pulses += chain.increase;
        end
        chk("up_count", pulses, 3);
        step();
        chk("up_val", val, 3);
        btn_start = 0; btn_load = 1;
        steps(7);
        chk("up_load", {state, chain.load_def, chain.increase}, {2'b00, 1'b1, 1'b0});
        btn_load = 0;
        steps(8);

        // Down to terminal 0000
        val = 2; mode_down = 1; btn_start = 1;
        steps(7);
        chk("dn_run", state, 2'b01);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            pulses += chain.decrease;
        end
        chk("dn_done", {state, done, chain.decrease}, {2'b11, 1'b1, 1'b0});
        chk("dn_count", pulses, 2);
        btn_start = 0;
        steps(8);
        chk("dn_hold", {state, val}, {2'b11, 32'd0});
        btn_start = 1;
        steps(7);
        chk("dn_restart", {state, chain.load_def}, {2'b00, 1'b1});
        step();
        chk("dn_ld_once", chain.load_def, 1'b0);
        btn_start = 0;
        steps(8);

        // Up to terminal 9999, no wrap
        val = 9998; mode_down = 0; btn_start = 1;
        steps(7);
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            pulses += chain.increase;
        end
        chk("ut_done", {state, done}, {2'b11, 1'b1});
        chk("ut_count", pulses, 1);
        steps(8);
        chk("ut_nowrap", val, 9999);
        btn_start = 0; btn_load = 1;
        steps(7);
        chk("ut_load", {state, chain.load_def}, {2'b00, 1'b1});
        btn_load = 0;
        steps(8);

        // Bounce rejection, then a clean press
        val = 0; dflt = 0;
        for (int i = 0; i < 10; i++) begin
            btn_start = (i % 2 == 0);
            step();
        end
        chk("bounce", state, 2'b00);
        btn_start = 1;
        steps(6);
        chk("clean_pre", state, 2'b00);
        step();
        chk("clean_run", state, 2'b01);

        // Pause with prescaler at 2, hold, resume phase, start+load together
        btn_start = 0;
        steps(8);
        btn_start = 1;
        steps(7);
        chk("pause", state, 2'b10);
        btn_start = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += chain.increase + chain.decrease + chain.load_def;
        end
        chk("pause_quiet", {state, 8'(pulses)}, {2'b10, 8'd0});
        btn_start = 1;
        steps(7);
        chk("resume", {state, chain.increase}, {2'b01, 1'b0});
        step();
        chk("resume_c1", chain.increase, 1'b0);
        step();
        chk("resume_c2", chain.increase, 1'b1);
        btn_start = 0;
        steps(8);
        btn_start = 1;
        steps(7);
        chk("pause2", state, 2'b10);
        btn_start = 0;
        steps(8);
        btn_start = 1; btn_load = 1;
        steps(7);
        chk("both_ev", {state, chain.load_def}, {2'b00, 1'b1});
        step();
        chk("both_ld_once", chain.load_def, 1'b0);
        btn_start = 0; btn_load = 0;
        steps(8);

        // Randomized stimulus against the reference model
        cs = 0; cl = 0; dflt = 9997;
        for (int c = 0; c < 5000; c++) begin
            if (c == 2500) dflt = 3;
            rst_n = ($urandom_range(0, 299) != 0);
            if (cs == 0) begin
                btn_start = $urandom_range(0, 1);
                cs = $urandom_range(1, 10);
            end else begin
                cs--;
            end
            if (cl == 0) begin
                btn_load = ($urandom_range(0, 4) == 0);
                cl = $urandom_range(1, 10);
            end else begin
                cl--;
            end
            if ($urandom_range(0, 49) == 0) mode_down = ~mode_down;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl_fsm.md
# count_ctrl_fsm

Run-control stage placed directly upstream of the 4-digit BCD up/down counter chain. It debounces the start/pause and load pushbuttons and divides the system clock into a count tick. A four-state FSM then drives the chain's least-significant digit: `increase`/`decrease` pulses, `load_def`, and the `switch_count`/`switch_up_down` mode levels. It watches the chain's BCD value so it can stop at 0000 when counting down or 9999 when counting up, with no wrap.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per count tick; must be ≥ 4.
- `DB_LEN`, default 1_000_000: cycles a synchronized button must be stable before it is accepted; must be ≥ 1.
- `clk`, in, 1: single system clock; all logic on posedge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `btn_start`, in, 1: raw start/pause button, active-high, asynchronous.
- `btn_load`, in, 1: raw load button, active-high, asynchronous.
- `mode_down`, in, 1: direction select, 1 = count down, 0 = count up.
- `digits`, in, 16: current chain value, 4 BCD digits, [3:0] = least-significant digit.
- `increase`, out, 1: one-cycle pulse to digit 0 in up mode.
- `decrease`, out, 1: one-cycle pulse to digit 0 in down mode.
- `load_def`, out, 1: one-cycle pulse; all digits load their defaults.
- `switch_count`, out, 1: level, 1 in up mode.
- `switch_up_down`, out, 1: level, 1 in down mode; always equals ~`switch_count`.
- `state`, out, 2: FSM state, IDLE=00, RUN=01, PAUSE=10, DONE=11.
- `done`, out, 1: high while in DONE.

## Operation
- **Button path**, per button:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level changes only after the synchronized input has been stable for DB_LEN consecutive cycles.
  - A rising edge of the debounced level gives a one-cycle event: `start_ev` or `load_ev`.
- **Direction register `dir`**: loaded from `mode_down` every cycle except in RUN, where it is frozen. `switch_up_down = dir`, `switch_count = ~dir`.
- **Prescaler**:
  - Counts 0..TICK_DIV-1 only in RUN.
  - `tick` fires when it is at TICK_DIV-1, then it wraps to 0.
  - Held in PAUSE; cleared in IDLE and DONE.
- **Terminal value**: `term` = (`dir`=1 and `digits`==16'h0000) or (`dir`=0 and `digits`==16'h9999).
- **FSM transitions** (`load_ev` takes priority over `start_ev` in the same cycle):
  - IDLE: `load_ev` → pulse `load_def`, stay in IDLE. `start_ev` → RUN.
  - RUN:
    - `load_ev` → pulse `load_def`, go to IDLE.
    - `start_ev` → PAUSE.
    - `tick` with `term` → DONE, no count pulse.
    - `tick` with no `term` → pulse `increase` (`dir`=0) or `decrease` (`dir`=1).
  - PAUSE: `load_ev` → pulse `load_def`, go to IDLE. `start_ev` → RUN.
  - DONE: `load_ev` or `start_ev` → pulse `load_def`, go to IDLE.
- **Pulse exclusivity**: at most one of `increase`, `decrease`, `load_def` is high in any cycle, and never for two consecutive cycles.
- **Event during a tick**: when `start_ev` and `tick` coincide in RUN, the transition to PAUSE wins and no count pulse is issued.

## Timing
- **Reset** (`rst_n` low at posedge):
  - `state`=IDLE, `done`=0.
  - `increase`=`decrease`=`load_def`=0.
  - `dir`=0, so `switch_count`=1 and `switch_up_down`=0.
  - Prescaler, debounce counters and synchronizers all cleared.
  - Reset mid-RUN aborts on that edge. No `load_def` is issued; the digit chain resets itself.
- **All outputs are registered.**
- **Count pulse latency**: the pulse is high in the cycle after the `tick` cycle. `term` is evaluated on `digits` in the `tick` cycle; `digits` is stable there because TICK_DIV ≥ 4.
- **First tick after entering RUN from IDLE**: TICK_DIV cycles after entry. Resuming from PAUSE continues the held count.
- **Button latency**: the event is high 2 (synchronizer) + DB_LEN + 1 cycles after the raw input has settled high.
- **Release**: holding a button produces one event only; a release followed by a re-press is required for the next.
- **Transition timing**: `state` changes on the edge that samples the event. A `load_def` pulse coincides with the first cycle of the new state.

## Structure
- **Package `count_ctrl_pkg`**:
  - State encoding constants: ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - BCD terminal constants: 16'h0000 and 16'h9999.
  - Default TICK_DIV and DB_LEN.
- **Sub-module `btn_debounce`** (params DB_LEN; ports `clk`, `rst_n`, `btn_raw`, `btn_ev`): synchronizer, debounce counter and edge detect. Instantiated twice.
- **Top level**: prescaler, `dir` register, `term` compare and FSM.

## Test plan
All scenarios use TICK_DIV=4 and DB_LEN=3, with a behavioural 4-digit BCD model closing the loop.
1. **Reset**: `rst_n`=0 for 2 cycles with buttons toggling → `state`=00, all pulses 0, `switch_count`=1, `switch_up_down`=0, `done`=0.
2. **Up count**: `mode_down`=0, digits=0000, press `btn_start` → RUN. `increase` is high for exactly 1 cycle every 4, and the model reaches 0003 after 12 RUN cycles. Toggling `mode_down` in RUN leaves `switch_count` unchanged.
3. **Down to terminal**: `mode_down`=1, digits=0002, start → two `decrease` pulses, then the next tick gives `state`=DONE, `done`=1, no third pulse. `btn_start` in DONE → `load_def` for 1 cycle and `state`=IDLE.
4. **Up terminal**: digits=9998, up, start → one `increase`, then DONE at 9999 with no wrap to 0000.
5. **Bounce**: `btn_start` toggling every cycle for 10 cycles → no event and no state change. Holding it high → exactly one `start_ev` 6 cycles after it settles.
6. **Pause/resume and priority**: start during RUN with the prescaler at 2 → PAUSE, no pulses for 20 cycles. Start again → first pulse 2 cycles after re-entering RUN. `start_ev` and `load_ev` together in PAUSE → `load_def` for 1 cycle, IDLE.
